// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage stallable floating-point multiplier with precision mask
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 2**(EXP_W-1)-1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   A,
    input  logic [EXP_W+MAN_W:0]   B,
    input  logic [MAN_W-2:0]       Conf_Bit_Mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   R,
    output logic                   out_ovf,
    output logic                   out_unf
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;

    localparam logic signed [EW-1:0]  BIAS_E  = EW'(BIAS);
    localparam logic signed [EW-1:0]  E_MAX   = EW'((2**EXP_W) - 1);
    localparam logic signed [EW-1:0]  ONE_E   = EW'(1);
    localparam logic [EXP_W-1:0]      EXP_SAT = EXP_W'((2**EXP_W) - 2);

    logic                  advance;

    logic                  s1_valid_q, s1_sign_q, s1_zero_q;
    logic signed [EW-1:0]  s1_esum_q;
    logic [MW-1:0]         s1_ma_q, s1_mb_q;

    logic                  s2_valid_q, s2_sign_q, s2_zero_q;
    logic signed [EW-1:0]  s2_esum_q;
    logic [PW-1:0]         s2_prod_q;

    logic                  out_valid_q, ovf_q, unf_q;
    logic [W-1:0]          r_q;

    logic                  s1_sign_d, s1_zero_d;
    logic signed [EW-1:0]  s1_esum_d;
    logic [MW-1:0]         s1_ma_d, s1_mb_d;
    logic [PW-1:0]         s2_prod_d;

    logic                  norm;
    logic [MAN_W-1:0]      frac_n;
    logic signed [EW-1:0]  e_n;
    logic [W-1:0]          r_d;
    logic                  ovf_d, unf_d;

    // The whole pipeline moves together; bubbles are never squeezed out.
    assign advance  = ~out_valid_q | out_ready;
    assign in_ready = advance;

    assign s1_sign_d = A[W-1] ^ B[W-1];
    assign s1_zero_d = (A[W-2:MAN_W] == '0) | (B[W-2:MAN_W] == '0);
    assign s1_esum_d = $signed({2'b00, A[W-2:MAN_W]}) + $signed({2'b00, B[W-2:MAN_W]}) - BIAS_E;
    assign s1_ma_d   = {1'b1, A[MAN_W-1], A[MAN_W-2:0] & Conf_Bit_Mask};
    assign s1_mb_d   = {1'b1, B[MAN_W-1], B[MAN_W-2:0] & Conf_Bit_Mask};

    assign s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);

    assign norm   = s2_prod_q[PW-1];
    assign frac_n = norm ? s2_prod_q[PW-2:MAN_W+1] : s2_prod_q[PW-3:MAN_W];
    assign e_n    = norm ? s2_esum_q + ONE_E : s2_esum_q;

    always_comb begin
        r_d   = {s2_sign_q, e_n[EXP_W-1:0], frac_n};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (s2_zero_q) begin
            r_d = {s2_sign_q, {(W-1){1'b0}}};
        end else if (e_n >= E_MAX) begin
            r_d   = {s2_sign_q, EXP_SAT, {MAN_W{1'b1}}};
            ovf_d = 1'b1;
        end else if (e_n[EW-1] || e_n == '0) begin
            r_d   = {s2_sign_q, EXP_W'(1), {MAN_W{1'b0}}};
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_esum_q   <= '0;
            s1_ma_q     <= '0;
            s1_mb_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_esum_q   <= '0;
            s2_prod_q   <= '0;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (advance) begin
            s1_valid_q  <= in_valid;
            s1_sign_q   <= s1_sign_d;
            s1_zero_q   <= s1_zero_d;
            s1_esum_q   <= s1_esum_d;
            s1_ma_q     <= s1_ma_d;
            s1_mb_q     <= s1_mb_d;
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_zero_q   <= s1_zero_q;
            s2_esum_q   <= s1_esum_q;
            s2_prod_q   <= s2_prod_d;
            // Bubbles leave R and flags cleared so nothing stale looks like a result.
            out_valid_q <= s2_valid_q;
            r_q         <= s2_valid_q ? r_d : '0;
            ovf_q       <= s2_valid_q & ovf_d;
            unf_q       <= s2_valid_q & unf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign R         = r_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - randomized bench for fp_mul_pipe against a real-arithmetic reference
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_ovf, out_unf;
    logic [31:0] A, B, R;
    logic [21:0] mask;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] qa[$], qb[$];
    logic [21:0] qm[$];
    logic [33:0] res[$];
    int          res_cyc[$], acc_cyc[$];
    logic        tr_ov[$], tr_or[$], tr_ir[$];
    logic [31:0] tr_r[$];
    bit          rand_idle, rand_stall;
    int          stall_from = -1, stall_to = -1;

    fp_mul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Conf_Bit_Mask(mask), .out_valid(out_valid),
        .out_ready(out_ready), .R(R), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    always #5 clk = ~clk;

    // Reference: values as reals, product exact in double, truncated by floor.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic [21:0] m);
        real pa, pb, p;
        int  e, f, fa, fb;
        logic s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {2'b00, s, 31'd0};
        fa = int'({a[22], a[21:0] & m});
        fb = int'({b[22], b[21:0] & m});
        pa = 1.0 + fa / 8388608.0;
        pb = 1.0 + fb / 8388608.0;
        p  = pa * pb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p >= 2.0) begin
            p = p / 2.0;
            e = e + 1;
        end
        f = $rtoi((p - 1.0) * 8388608.0);
        if (e >= 255) return {2'b10, s, 8'hFE, 23'h7FFFFF};
        if (e <= 0)   return {2'b01, s, 8'h01, 23'h0};
        return {2'b00, s, e[7:0], f[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op(input bit tame);
        logic [7:0] e;
        if (tame) e = 8'($urandom_range(140, 100));
        else      e = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(255));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    // Drives queued ops and records every cycle; compares nothing itself.
    task automatic run_ops(input int max_cyc);
        int c = 0;
        int idx = 0;
        res.delete(); res_cyc.delete(); acc_cyc.delete();
        tr_ov.delete(); tr_or.delete(); tr_ir.delete(); tr_r.delete();
        while ((idx < qa.size() || res.size() < qa.size()) && c < max_cyc) begin
            @(negedge clk);
            out_ready = !((c >= stall_from && c <= stall_to) || (rand_stall && $urandom_range(3) == 0));
            if (idx < qa.size() && !(rand_idle && $urandom_range(3) == 0)) begin
                in_valid = 1'b1; A = qa[idx]; B = qb[idx]; mask = qm[idx];
            end else begin
                in_valid = 1'b0; A = $urandom; B = $urandom;
            end
            #1;
            tr_ov.push_back(out_valid); tr_or.push_back(out_ready);
            tr_ir.push_back(in_ready);  tr_r.push_back(R);
            if (in_valid && in_ready) begin
                acc_cyc.push_back(c);
                idx++;
            end
            if (out_valid && out_ready) begin
                res.push_back({out_ovf, out_unf, R});
                res_cyc.push_back(c);
            end
            c++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; mask = '1;
        repeat (2) @(negedge clk);
        n_cmp += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        if (R !== 32'h0)        begin n_fail++; $display("FAIL reset_R got %h want 0", R); end
        if (out_ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
        if (out_unf !== 1'b0)   begin n_fail++; $display("FAIL reset_unf got %b want 0", out_unf); end
        if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [33:0] want[6];
        want = '{{2'b00, 32'h40C00000}, {2'b00, 32'h40100000}, {2'b10, 32'hFF7FFFFF},
                 {2'b01, 32'h00800000}, {2'b00, 32'h00000000}, {2'b00, 32'h3FC00000}};
        qa = '{32'h40000000, 32'h3FC00000, 32'h7F000000, 32'h00800000, 32'h00000000, 32'h3FE00000};
        qb = '{32'h40400000, 32'h3FC00000, 32'hFF000000, 32'h00800000, 32'h40000000, 32'h3F800000};
        qm = '{22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF, 22'h3FFFFF, 22'h0};
        rand_idle = 0; rand_stall = 0; stall_from = -1; stall_to = -1;
        run_ops(60);
        n_cmp++;
        if (res.size() != 6) begin n_fail++; $display("FAIL dir_count got %0d want 6", res.size()); end
        for (int i = 0; i < 6; i++) begin
            n_cmp += 2;
            if (res[i] !== want[i]) begin
                n_fail++; $display("FAIL dir_result[%0d] got %h want %h", i, res[i], want[i]);
            end
            if (res_cyc[i] - acc_cyc[i] != 3) begin
                n_fail++; $display("FAIL dir_latency[%0d] got %0d want 3", i, res_cyc[i] - acc_cyc[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int stalled_valid = 0;
        qa.delete(); qb.delete(); qm.delete();
        for (int i = 0; i < 8; i++) begin
            qa.push_back(rnd_op(1)); qb.push_back(rnd_op(1)); qm.push_back(22'($urandom));
        end
        rand_idle = 0; rand_stall = 0; stall_from = 4; stall_to = 6;
        run_ops(100);
        for (int c = 0; c < tr_ov.size(); c++) begin
            n_cmp++;
            if (tr_ir[c] !== (!tr_ov[c] || tr_or[c])) begin
                n_fail++; $display("FAIL b2b_in_ready[c%0d] got %b want %b", c, tr_ir[c], !tr_ov[c] || tr_or[c]);
            end
            if (tr_ov[c] && !tr_or[c]) stalled_valid++;
            if (c > 0 && tr_ov[c-1] && !tr_or[c-1]) begin
                n_cmp++;
                if (tr_ov[c] !== 1'b1 || tr_r[c] !== tr_r[c-1]) begin
                    n_fail++; $display("FAIL b2b_hold[c%0d] got %b/%h want 1/%h", c, tr_ov[c], tr_r[c], tr_r[c-1]);
                end
            end
        end
        n_cmp += 2;
        if (stalled_valid != 3) begin n_fail++; $display("FAIL b2b_stall_cycles got %0d want 3", stalled_valid); end
        if (res.size() != 8)    begin n_fail++; $display("FAIL b2b_count got %0d want 8", res.size()); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (res[i] !== model(qa[i], qb[i], qm[i])) begin
                n_fail++; $display("FAIL b2b_result[%0d] got %h want %h", i, res[i], model(qa[i], qb[i], qm[i]));
            end
        end
        stall_from = -1; stall_to = -1;
    endtask

    task automatic test_random();
        qa.delete(); qb.delete(); qm.delete();
        for (int i = 0; i < 300; i++) begin
            qa.push_back(rnd_op(0)); qb.push_back(rnd_op(0));
            qm.push_back(($urandom_range(1) == 0) ? 22'h3FFFFF : 22'($urandom));
        end
        rand_idle = 1; rand_stall = 1;
        run_ops(4000);
        n_cmp++;
        if (res.size() != 300) begin n_fail++; $display("FAIL rnd_count got %0d want 300", res.size()); end
        for (int i = 0; i < 300; i++) begin
            n_cmp++;
            if (res[i] !== model(qa[i], qb[i], qm[i])) begin
                n_fail++; $display("FAIL rnd_result[%0d] a=%h b=%h m=%h got %h want %h",
                                   i, qa[i], qb[i], qm[i], res[i], model(qa[i], qb[i], qm[i]));
            end
        end
        for (int c = 0; c < tr_ov.size(); c++) begin
            n_cmp++;
            if (tr_ir[c] !== (!tr_ov[c] || tr_or[c])) begin
                n_fail++; $display("FAIL rnd_in_ready[c%0d] got %b want %b", c, tr_ir[c], !tr_ov[c] || tr_or[c]);
            end
        end
        rand_idle = 0; rand_stall = 0;
    endtask

    task automatic test_reset_midflight();
        int spurious = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; A = rnd_op(1); B = rnd_op(1); mask = '1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid got %b want 0", out_valid); end
        if (R !== 32'h0)        begin n_fail++; $display("FAIL mid_async_R got %h want 0", R); end
        if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        qa = '{32'h40000000}; qb = '{32'h40400000}; qm = '{22'h3FFFFF};
        run_ops(30);
        repeat (5) begin
            @(negedge clk); #1;
            if (out_valid) spurious++;
        end
        n_cmp += 4;
        if (res.size() != 1) begin n_fail++; $display("FAIL mid_count got %0d want 1", res.size()); end
        if (res[0] !== {2'b00, 32'h40C00000}) begin n_fail++; $display("FAIL mid_result got %h want %h", res[0], {2'b00, 32'h40C00000}); end
        if (res_cyc[0] - acc_cyc[0] != 3) begin n_fail++; $display("FAIL mid_latency got %0d want 3", res_cyc[0] - acc_cyc[0]); end
        if (spurious != 0) begin n_fail++; $display("FAIL mid_spurious got %0d want 0", spurious); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
